set_assoc_cache: RTL and testbench

//  Parametrised N-way set-associative, write-through, no-write-allocate data cache.
//  - Sits between the PULPino core data port and the memory/bus port.
//  - Uses the same req/gnt/rvalid handshake on both sides.
//  - Adds per-set round-robin replacement, byte-masked write-through, an uncached

---
 rtl/set_assoc_cache_if.sv | 22 ++
 rtl/set_assoc_cache.sv | 220 ++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_assoc_cache_if.sv
// Request/grant/rvalid bus shared by the core side and the memory side of the cache.
interface set_assoc_cache_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output req, addr, wdata, we, be,
        input  gnt, rvalid, rdata, error
    );

    modport slave (
        input  req, addr, wdata, we, be,
        output gnt, rvalid, rdata, error
    );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate data cache, one word per line.
// Round-robin victim per set, uncached bypass window and a one-set-per-cycle flush.
module set_assoc_cache #(
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned NUM_WAYS      = 2,
    parameter logic [31:0] UNCACHED_BASE = 32'h1A10_0000,
    parameter logic [31:0] UNCACHED_MASK = 32'hFFF0_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    output logic              flush_busy_o,
    set_assoc_cache_if.slave  core,
    set_assoc_cache_if.master mem
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [3:0] {
        StIdle, StLookup, StRefillReq, StRefillWait, StWrReq, StWrWait,
        StBypReq, StBypWait, StResp, StFlush
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic             we_q, err_q;
    logic [3:0]       be_q;
    logic [IDX_W-1:0] flush_idx_q;

    logic             valid_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [31:0]      data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] rr_q    [NUM_SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             uncached;
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, rr_cur, rr_inc;
    logic [31:0]      merged;
    logic             refill_ok, wr_hit;

    assign idx      = addr_q[2 +: IDX_W];
    assign tag      = addr_q[31 -: TAG_W];
    assign uncached = (addr_q & UNCACHED_MASK) == UNCACHED_BASE;
    assign rr_cur   = rr_q[idx];
    assign rr_inc   = (int'(rr_cur) == int'(NUM_WAYS) - 1) ? '0 : rr_cur + 1'b1;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim = rr_cur;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim = WAY_W'(w);
        end
    end

    // Byte-merge the latched write data into the hit line.
    always_comb begin
        merged = data_q[idx][hit_way];
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    assign refill_ok = (state_q == StRefillWait) && mem.rvalid && !mem.error;
    assign wr_hit    = (state_q == StLookup) && !uncached && we_q && hit;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state decode and all bus outputs.
    always_comb begin
        state_d      = state_q;
        core.gnt     = 1'b0;
        core.rvalid  = 1'b0;
        core.rdata   = '0;
        core.error   = 1'b0;
        mem.req      = 1'b0;
        mem.addr     = '0;
        mem.wdata    = '0;
        mem.we       = 1'b0;
        mem.be       = '0;
        flush_busy_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = StFlush;
                end else if (core.req) begin
                    core.gnt = 1'b1;
                    state_d  = StLookup;
                end
            end
            StLookup: begin
                if (uncached)  state_d = StBypReq;
                else if (we_q) state_d = StWrReq;
                else if (hit)  state_d = StResp;
                else           state_d = StRefillReq;
            end
            StRefillReq, StRefillWait: begin
                mem.req   = (state_q == StRefillReq);
                mem.addr  = {addr_q[31:2], 2'b00};
                mem.wdata = wdata_q;
                mem.be    = 4'b1111;
                if (state_q == StRefillReq && mem.gnt)   state_d = StRefillWait;
                if (state_q == StRefillWait && mem.rvalid) state_d = StResp;
            end
            StWrReq, StWrWait: begin
                mem.req   = (state_q == StWrReq);
                mem.addr  = {addr_q[31:2], 2'b00};
                mem.wdata = wdata_q;
                mem.we    = 1'b1;
                mem.be    = be_q;
                if (state_q == StWrReq && mem.gnt)     state_d = StWrWait;
                if (state_q == StWrWait && mem.rvalid) state_d = StResp;
            end
            StBypReq, StBypWait: begin
                mem.req   = (state_q == StBypReq);
                mem.addr  = {addr_q[31:2], 2'b00};
                mem.wdata = wdata_q;
                mem.we    = we_q;
                mem.be    = be_q;
                if (state_q == StBypReq && mem.gnt)     state_d = StBypWait;
                if (state_q == StBypWait && mem.rvalid) state_d = StResp;
            end
            StResp: begin
                core.rvalid = 1'b1;
                core.rdata  = rdata_q;
                core.error  = err_q;
                // A flush arriving here is dropped; the requester retries it.
                if (core.req && !flush_i) begin
                    core.gnt = 1'b1;
                    state_d  = StLookup;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                flush_busy_o = 1'b1;
                if (flush_idx_q == IDX_W'(NUM_SETS - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (reset) core.gnt = 1'b0;
    end

    // Request latch, response capture and flush walk counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            flush_idx_q <= '0;
        end else begin
            if (core.gnt) begin
                addr_q  <= core.addr;
                wdata_q <= core.wdata;
                we_q    <= core.we;
                be_q    <= core.be;
            end
            if (state_q == StLookup && !uncached && !we_q && hit) begin
                rdata_q <= data_q[idx][hit_way];
                err_q   <= 1'b0;
            end else if ((state_q == StRefillWait || state_q == StWrWait ||
                          state_q == StBypWait) && mem.rvalid) begin
                rdata_q <= mem.rdata;
                err_q   <= mem.error;
            end
            flush_idx_q <= (state_q == StFlush) ? flush_idx_q + 1'b1 : '0;
        end
    end

    // Valid bits and round-robin pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < int'(NUM_WAYS); w++) valid_q[s][w] <= 1'b0;
            end
        end else if (state_q == StFlush) begin
            rr_q[flush_idx_q] <= '0;
            for (int w = 0; w < int'(NUM_WAYS); w++) valid_q[flush_idx_q][w] <= 1'b0;
        end else if (refill_ok) begin
            valid_q[idx][victim] <= 1'b1;
            if (victim == rr_cur) rr_q[idx] <= rr_inc;
        end
    end

    // Tag and data arrays; no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_hit) data_q[idx][hit_way] <= merged;
            if (refill_ok) begin
                data_q[idx][victim] <= mem.rdata;
                tag_q[idx][victim]  <= tag;
            end
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench: directed vector table, flush/reset sequences, then random traffic
// against a line-level cache model.
module tb_set_assoc_cache;
    localparam int unsigned NS    = 64;
    localparam int unsigned NW    = 2;
    localparam int unsigned IB    = $clog2(NS);
    localparam logic [31:0] UBASE = 32'h1A10_0000;
    localparam logic [31:0] UMASK = 32'hFFF0_0000;

    logic clk = 1'b0;
    logic reset, flush, flush_busy;

    set_assoc_cache_if core_bus();
    set_assoc_cache_if mem_bus();

    set_assoc_cache #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .UNCACHED_BASE(UBASE), .UNCACHED_MASK(UMASK)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .flush_busy_o(flush_busy),
        .core(core_bus), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event never arrived", name);
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int          mem_txn = 0;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic        last_we, last_err;
    logic [3:0]  last_be;
    int          gnt_pct = 100, max_dly = 0, err_pct = 0;
    bit          force_err = 0, hold_resp = 0;

    initial begin
        int dly;
        bit pend;
        pend = 0;
        dly  = 0;
        mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0; mem_bus.error = 0;
        forever begin
            @(negedge clk);
            mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0; mem_bus.error = 0;
            if (reset) begin
                pend = 0;
            end else if (pend) begin
                if (dly > 0) dly--;
                else if (!hold_resp) begin
                    mem_bus.rvalid = 1; mem_bus.rdata = last_rdata; mem_bus.error = last_err;
                    pend = 0;
                end
            end else if (mem_bus.req === 1'b1 && int'($urandom_range(99)) < gnt_pct) begin
                mem_bus.gnt = 1;
                pend = 1;
                dly  = int'($urandom_range(max_dly));
                mem_txn++;
                last_addr = mem_bus.addr; last_we = mem_bus.we; last_be = mem_bus.be;
                last_wdata = mem_bus.wdata;
                last_err = force_err || (err_pct > 0 && int'($urandom_range(99)) < err_pct);
                if (mem_bus.we) begin
                    logic [31:0] cur;
                    cur = mem_arr.exists(mem_bus.addr) ? mem_arr[mem_bus.addr] : ~mem_bus.addr;
                    for (int b = 0; b < 4; b++)
                        if (mem_bus.be[b]) cur[8*b +: 8] = mem_bus.wdata[8*b +: 8];
                    if (!last_err) mem_arr[mem_bus.addr] = cur;
                    last_rdata = 32'h0;
                end else begin
                    last_rdata = mem_arr.exists(mem_bus.addr) ? mem_arr[mem_bus.addr] : ~mem_bus.addr;
                end
            end
        end
    end

    // ---------------- reference model: sets of {valid, tag, data} + RR ----------------
    bit          mv  [NS][NW];
    logic [31:0] mt  [NS][NW];
    logic [31:0] md  [NS][NW];
    int          mrr [NS];

    task automatic model_clear();
        for (int s = 0; s < int'(NS); s++) begin
            mrr[s] = 0;
            for (int w = 0; w < int'(NW); w++) mv[s][w] = 0;
        end
    endtask

    // One core access, checked against the model; returns what was observed.
    task automatic check_access(input logic [31:0] a, input logic w, input logic [3:0] b,
                                input logic [31:0] d, input bit ferr,
                                output logic [31:0] o_rdata, output logic o_err,
                                output int o_mem, output int o_lat);
        int idx, hw, m0, v;
        logic [31:0] tg, line;
        bit unc, hit, done;
        idx = int'((a >> 2) % NS);
        tg  = a >> (2 + IB);
        unc = (a & UMASK) == UBASE;
        hit = 0; hw = 0;
        for (int i = 0; i < int'(NW); i++)
            if (!hit && mv[idx][i] && mt[idx][i] == tg) begin hit = 1; hw = i; end
        o_rdata = 'x; o_err = 'x; o_mem = -1; o_lat = -1;
        force_err = ferr;
        core_bus.addr = a; core_bus.we = w; core_bus.be = b; core_bus.wdata = d;
        core_bus.req = 1;
        done = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            #1;
            if (core_bus.gnt === 1'b1) done = 1;
            else @(negedge clk);
        end
        if (!done) begin core_bus.req = 0; fail_now("core_gnt"); return; end
        m0 = mem_txn;
        o_lat = 0; done = 0;
        while (!done && o_lat < 500) begin
            @(negedge clk);
            core_bus.req = 0;
            o_lat++;
            #1;
            if (core_bus.rvalid === 1'b1) done = 1;
        end
        if (!done) begin fail_now("core_rvalid"); return; end
        o_rdata = core_bus.rdata; o_err = core_bus.error; o_mem = mem_txn - m0;

        if (unc) begin
            chk("byp_mem_count", o_mem, 1);
            chk("byp_addr", last_addr, {a[31:2], 2'b00});
            chk("byp_we_be", {last_we, last_be}, {w, b});
            chk("byp_rdata", o_rdata, last_rdata);
            chk("byp_err", o_err, last_err);
        end else if (w) begin
            chk("wr_mem_count", o_mem, 1);
            chk("wr_addr", last_addr, {a[31:2], 2'b00});
            chk("wr_we_be", {last_we, last_be}, {1'b1, b});
            chk("wr_wdata", last_wdata, d);
            chk("wr_err", o_err, last_err);
            if (hit) begin
                line = md[idx][hw];
                for (int k = 0; k < 4; k++) if (b[k]) line[8*k +: 8] = d[8*k +: 8];
                md[idx][hw] = line;
            end
        end else if (hit) begin
            chk("rd_hit_mem_count", o_mem, 0);
            chk("rd_hit_rdata", o_rdata, md[idx][hw]);
            chk("rd_hit_err", o_err, 0);
            chk("rd_hit_latency", o_lat, 2);
        end else begin
            chk("rd_miss_mem_count", o_mem, 1);
            chk("rd_miss_addr", last_addr, {a[31:2], 2'b00});
            chk("rd_miss_we_be", {last_we, last_be}, 5'b0_1111);
            chk("rd_miss_rdata", o_rdata, last_rdata);
            chk("rd_miss_err", o_err, last_err);
            if (!last_err) begin
                v = -1;
                for (int i = 0; i < int'(NW); i++) if (v < 0 && !mv[idx][i]) v = i;
                if (v < 0) v = mrr[idx];
                mv[idx][v] = 1; mt[idx][v] = tg; md[idx][v] = last_rdata;
                if (v == mrr[idx]) mrr[idx] = (mrr[idx] + 1) % int'(NW);
            end
        end
    endtask

    // Flush pulse; optionally hold a read request through it to show it is stalled.
    task automatic do_flush(input bit hold_req, input logic [31:0] a);
        int busy_n;
        bit saw_gnt, ended;
        @(negedge clk);
        flush = 1;
        if (hold_req) begin
            core_bus.addr = a; core_bus.we = 0; core_bus.be = 4'hF; core_bus.req = 1;
            #1 chk("flush_priority_no_gnt", core_bus.gnt, 0);
        end
        @(negedge clk);
        flush = 0;
        busy_n = 0; saw_gnt = 0; ended = 0;
        for (int n = 0; n < 300 && !ended; n++) begin
            #1;
            if (flush_busy === 1'b1) begin
                busy_n++;
                if (core_bus.gnt === 1'b1) saw_gnt = 1;
                @(negedge clk);
            end else begin
                ended = 1;
            end
        end
        chk("flush_busy_cycles", busy_n, NS);
        chk("flush_no_gnt", saw_gnt, 0);
        model_clear();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          ferr;
        int          exp_mem;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic run_vec(input int i);
        logic [31:0] rd;
        logic er;
        int mc, lt;
        check_access(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, vecs[i].ferr,
                     rd, er, mc, lt);
        chk($sformatf("vec%0d_mem_count", i), mc, vecs[i].exp_mem);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        if (vecs[i].exp_mem == 0) chk($sformatf("vec%0d_hit_latency", i), lt, 2);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic er;
        int mc, lt, m0;
        bit done, saw_rv;

        //            addr          we  be     wdata          ferr mem rdata          err
        vecs[0]  = '{32'h0000_0000, 0, 4'hF, 32'h0,         0,   1, 32'h0000_1111, 0};
        vecs[1]  = '{32'h0000_0100, 0, 4'hF, 32'h0,         0,   1, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{32'h0000_0200, 0, 4'hF, 32'h0,         0,   1, 32'h0000_2222, 0};
        vecs[3]  = '{32'h0000_0100, 0, 4'hF, 32'h0,         0,   0, 32'hDEAD_BEEF, 0};
        vecs[4]  = '{32'h0000_0000, 0, 4'hF, 32'h0,         0,   1, 32'h0000_1111, 0};
        vecs[5]  = '{32'h0000_0300, 1, 4'hF, 32'h1234_5678, 0,   1, 32'h0000_0000, 0};
        vecs[6]  = '{32'h0000_0300, 0, 4'hF, 32'h0,         0,   1, 32'h1234_5678, 0};
        vecs[7]  = '{32'h0000_0300, 0, 4'hF, 32'h0,         0,   0, 32'h1234_5678, 0};
        vecs[8]  = '{32'h1A10_0004, 0, 4'hF, 32'h0,         0,   1, 32'hCAFE_0004, 0};
        vecs[9]  = '{32'h1A10_0004, 0, 4'hF, 32'h0,         1,   1, 32'hCAFE_0004, 1};
        vecs[10] = '{32'h0000_0100, 0, 4'hF, 32'h0,         0,   1, 32'h1122_3344, 0};
        vecs[11] = '{32'h0000_0100, 1, 4'h2, 32'h0000_AA00, 0,   1, 32'h0000_0000, 0};
        vecs[12] = '{32'h0000_0100, 0, 4'hF, 32'h0,         0,   0, 32'h1122_AA44, 0};

        mem_arr[32'h0000_0000] = 32'h0000_1111;
        mem_arr[32'h0000_0100] = 32'hDEAD_BEEF;
        mem_arr[32'h0000_0200] = 32'h0000_2222;
        mem_arr[32'h1A10_0004] = 32'hCAFE_0004;

        // Reset state, with a request pending to show gnt is held off.
        reset = 1; flush = 0;
        core_bus.req = 1; core_bus.addr = 0; core_bus.wdata = 0; core_bus.we = 0;
        core_bus.be = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", core_bus.gnt, 0);
        chk("rst_rvalid", core_bus.rvalid, 0);
        chk("rst_rdata", core_bus.rdata, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_mem_req", mem_bus.req, 0);
        chk("rst_mem_addr_wdata", mem_bus.addr | mem_bus.wdata, 0);
        core_bus.req = 0;
        reset = 0;
        model_clear();
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Flush with a stalled request, then previously cached lines must miss.
        do_flush(1, 32'h0000_0000);
        check_access(32'h0000_0000, 0, 4'hF, 0, 0, rd, er, mc, lt);
        chk("post_flush_0x000_miss", mc, 1);
        check_access(32'h0000_0300, 0, 4'hF, 0, 0, rd, er, mc, lt);
        chk("post_flush_0x300_miss", mc, 1);

        mem_arr[32'h0000_0100] = 32'h1122_3344;
        for (int i = 10; i < 13; i++) run_vec(i);

        // Reset while a refill response is outstanding.
        hold_resp = 1;
        @(negedge clk);
        core_bus.addr = 32'h0000_0400; core_bus.we = 0; core_bus.be = 4'hF; core_bus.req = 1;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (core_bus.gnt === 1'b1) done = 1;
            else @(negedge clk);
        end
        m0 = mem_txn;
        @(negedge clk);
        core_bus.req = 0;
        for (int n = 0; n < 100 && mem_txn == m0; n++) @(negedge clk);
        if (!done || mem_txn == m0) fail_now("refill_wait_setup");
        @(negedge clk);
        reset = 1;
        saw_rv = 0;
        for (int n = 0; n < 13; n++) begin
            if (n == 3) begin reset = 0; hold_resp = 0; end
            #1;
            if (core_bus.rvalid === 1'b1) saw_rv = 1;
            @(negedge clk);
        end
        chk("reset_abandons_refill", saw_rv, 0);
        model_clear();
        check_access(32'h0000_0300, 0, 4'hF, 0, 0, rd, er, mc, lt);
        chk("post_reset_0x300_miss", mc, 1);
        check_access(32'h0000_0100, 0, 4'hF, 0, 0, rd, er, mc, lt);
        chk("post_reset_0x100_miss", mc, 1);

        // Random traffic on a few sets and tags so hits, evictions and errors mix.
        gnt_pct = 60; max_dly = 3; err_pct = 10;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(99) < 3) begin
                do_flush(0, 0);
            end else begin
                if ($urandom_range(3) == 0) @(negedge clk);
                if ($urandom_range(15) == 0)
                    a = UBASE + 32'($urandom_range(3) << 2);
                else
                    a = 32'(($urandom_range(3) << (2 + IB)) | ($urandom_range(3) << 2) |
                            $urandom_range(3));
                check_access(a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom, 0,
                             rd, er, mc, lt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
